// File: rtl/riscv_pkg.sv
// Shared types for the core sequencer: state encoding and watchdog default.
package riscv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_READ   = 3'd3,
      ST_EXEC   = 3'd4,
      ST_MEM    = 3'd5,
      ST_WB     = 3'd6,
      ST_HALTED = 3'd7
   } seq_state_t;

   localparam int SEQ_TIMEOUT_DEFAULT = 16;

   // States that sit waiting on a unit's ready/done handshake.
   function automatic logic is_wait_state(input seq_state_t s);
      return (s == ST_FETCH) || (s == ST_READ) || (s == ST_EXEC) || (s == ST_MEM);
   endfunction

endpackage

// File: rtl/core_sequencer_watchdog.sv
// seq_watchdog: clearable up-counter that saturates at TIMEOUT_CYCLES-1 and flags terminal count.
module seq_watchdog
   import riscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic tc
);
   localparam int            CW     = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != TC_VAL)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer with per-stage go strobes and handshake watchdog.
// Build option CORE_SEQ_STEP_EN: single-step, one instruction per falling edge of en.
//
// state   | meaning
// IDLE    | waiting for a start condition (also parked here while err is set)
// FETCH   | instruction memory read, wait imem_rdy
// DECODE  | one-cycle decode
// READ    | register operand read, wait reg_rdy; class latched on exit
// EXEC    | ALU operation, wait alu_done; branch_taken latched on exit
// MEM     | load/store, wait mem_ack
// WB      | writeback + PC update, one cycle, retires the instruction
// HALTED  | stopped at instruction boundary until halt drops
module core_sequencer
   import riscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 halt,
   input  logic                 imem_rdy,
   input  logic                 reg_rdy,
   input  logic                 alu_done,
   input  logic                 mem_ack,
   input  logic                 load_instr,
   input  logic                 store_instr,
   input  logic                 branch_instr,
   input  logic                 branch_taken,
   output logic                 fetch_go,
   output logic                 decode_go,
   output logic                 read_go,
   output logic                 exec_go,
   output logic                 mem_go,
   output logic                 wb_go,
   output logic                 pc_go,
   output logic                 sel_pc_src,
   output logic                 busy,
   output logic                 err,
   output logic                 boot_ok,
   output logic [CNT_WIDTH-1:0] instr_count,
   output logic [2:0]           state
);
   seq_state_t           state_q, state_d;
   logic                 first_q, first_d;
   logic                 err_q, err_d;
   logic                 boot_ok_q, boot_ok_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 is_load_q, is_load_d;
   logic                 is_store_q, is_store_d;
   logic                 is_branch_q, is_branch_d;
   logic                 taken_q, taken_d;
   logic                 hs, start, timeout, entering;
   logic                 wd_clr, wd_inc, wd_tc;

`ifdef CORE_SEQ_STEP_EN
   logic en_q, en_d, pend_q, pend_d, en_fall, consume;

   assign en_d    = en;
   assign en_fall = en_q & ~en;
   assign start   = en_fall | pend_q;
   assign consume = (state_d == ST_FETCH) && (state_q != ST_FETCH);

   // A pulse that lands mid-instruction is held until the next boundary.
   always_comb begin
      pend_d = consume ? (pend_q & en_fall) : (pend_q | en_fall);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q   <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         en_q   <= en_d;
         pend_q <= pend_d;
      end
   end
`else
   assign start = en;
`endif

   always_comb begin
      hs = 1'b0;
      case (state_q)
         ST_FETCH: hs = imem_rdy;
         ST_READ:  hs = reg_rdy;
         ST_EXEC:  hs = alu_done;
         ST_MEM:   hs = mem_ack;
         default:  hs = 1'b0;
      endcase
   end

   assign timeout  = !err_q && is_wait_state(state_q) && !hs && wd_tc;
   assign entering = (state_d != state_q);
   assign wd_clr   = entering | err_q;
   assign wd_inc   = is_wait_state(state_q) && !hs;

   seq_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk (clk),
      .rst (rst),
      .clr (wd_clr),
      .inc (wd_inc),
      .tc  (wd_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (err_q || timeout) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (start && !halt) state_d = ST_FETCH;
            ST_FETCH:  if (imem_rdy) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_READ;
            ST_READ:   if (reg_rdy) state_d = ST_EXEC;
            ST_EXEC:   if (alu_done) state_d = (is_load_q || is_store_q) ? ST_MEM : ST_WB;
            ST_MEM:    if (mem_ack) state_d = ST_WB;
            ST_WB: begin
               if (halt)       state_d = ST_HALTED;
               else if (start) state_d = ST_FETCH;
               else            state_d = ST_IDLE;
            end
            ST_HALTED: if (!halt) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
      first_d = entering;
   end

   always_comb begin
      err_d       = err_q | timeout;
      boot_ok_d   = boot_ok_q | (state_q == ST_WB);
      cnt_d       = cnt_q;
      if (state_q == ST_WB) cnt_d = cnt_q + 1'b1;
      is_load_d   = is_load_q;
      is_store_d  = is_store_q;
      is_branch_d = is_branch_q;
      taken_d     = taken_q;
      if (state_q == ST_READ && reg_rdy) begin
         is_load_d   = load_instr;
         is_store_d  = store_instr;
         is_branch_d = branch_instr;
      end
      if (state_q == ST_EXEC && alu_done) taken_d = branch_taken;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q       <= 1'b0;
         boot_ok_q   <= 1'b0;
         cnt_q       <= '0;
         is_load_q   <= 1'b0;
         is_store_q  <= 1'b0;
         is_branch_q <= 1'b0;
         taken_q     <= 1'b0;
      end else begin
         err_q       <= err_d;
         boot_ok_q   <= boot_ok_d;
         cnt_q       <= cnt_d;
         is_load_q   <= is_load_d;
         is_store_q  <= is_store_d;
         is_branch_q <= is_branch_d;
         taken_q     <= taken_d;
      end
   end

   always_comb begin
      fetch_go  = 1'b0;
      decode_go = 1'b0;
      read_go   = 1'b0;
      exec_go   = 1'b0;
      mem_go    = 1'b0;
      wb_go     = 1'b0;
      pc_go     = 1'b0;
      case (state_q)
         ST_FETCH:  fetch_go  = first_q;
         ST_DECODE: decode_go = first_q;
         ST_READ:   read_go   = first_q;
         ST_EXEC:   exec_go   = first_q;
         ST_MEM:    mem_go    = first_q;
         ST_WB: begin
            // Stores and branches have no register result to write back.
            wb_go = first_q & ~(is_store_q | is_branch_q);
            pc_go = 1'b1;
         end
         default: ;
      endcase
      sel_pc_src  = (state_q == ST_WB) & is_branch_q & taken_q;
      busy        = (state_q != ST_IDLE) && (state_q != ST_HALTED);
      err         = err_q;
      boot_ok     = boot_ok_q;
      instr_count = cnt_q;
      state       = state_q;
   end

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: per-instruction phase model with random handshake delays.
module tb_core_sequencer;
   import riscv_pkg::*;

   localparam int TO = 16;
   localparam int CW = 32;

   localparam logic [6:0] G_FETCH = 7'b1000000;
   localparam logic [6:0] G_DEC   = 7'b0100000;
   localparam logic [6:0] G_READ  = 7'b0010000;
   localparam logic [6:0] G_EXEC  = 7'b0001000;
   localparam logic [6:0] G_MEM   = 7'b0000100;

   logic          clk = 1'b0;
   logic          rst, en, halt, imem_rdy, reg_rdy, alu_done, mem_ack;
   logic          load_instr, store_instr, branch_instr, branch_taken;
   logic          fetch_go, decode_go, read_go, exec_go, mem_go, wb_go, pc_go;
   logic          sel_pc_src, busy, err, boot_ok;
   logic [CW-1:0] instr_count;
   logic [2:0]    state;

   int n_checks = 0;
   int n_fail   = 0;
   int retired  = 0;

   core_sequencer #(
      .TIMEOUT_CYCLES(TO),
      .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .halt(halt),
      .imem_rdy(imem_rdy), .reg_rdy(reg_rdy), .alu_done(alu_done), .mem_ack(mem_ack),
      .load_instr(load_instr), .store_instr(store_instr), .branch_instr(branch_instr),
      .branch_taken(branch_taken),
      .fetch_go(fetch_go), .decode_go(decode_go), .read_go(read_go), .exec_go(exec_go),
      .mem_go(mem_go), .wb_go(wb_go), .pc_go(pc_go), .sel_pc_src(sel_pc_src),
      .busy(busy), .err(err), .boot_ok(boot_ok), .instr_count(instr_count), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] obs();
      return {18'd0, state, fetch_go, decode_go, read_go, exec_go, mem_go, wb_go, pc_go,
              sel_pc_src, busy, err, boot_ok};
   endfunction

   // Expected output vector: busy follows the state rule, strobes given explicitly.
   function automatic logic [31:0] expv(input logic [2:0] st, input logic [6:0] go,
                                        input logic sel, input logic er, input logic boot);
      logic bz;
      bz = (st != 3'd0) && (st != 3'd7);
      return {18'd0, st, go, sel, bz, er, boot};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_noise();
      imem_rdy     = 1'($urandom);
      reg_rdy      = 1'($urandom);
      alu_done     = 1'($urandom);
      mem_ack      = 1'($urandom);
      {load_instr, store_instr, branch_instr} = 3'($urandom);
      branch_taken = 1'($urandom);
   endtask

   task automatic reset_in_read();
      check_val("pre_rst_read", obs(), expv(3'd3, G_READ, 1'b0, 1'b0, retired > 0));
      reg_rdy = 1'b0;
      #3 rst = 1'b1;
      #1;
      check_val("async_rst", obs(), 32'd0);
      check_val("async_rst_cnt", instr_count, 32'd0);
      retired = 0;
      for (int i = 0; i < 3; i++) begin
         drive_noise();
         tick();
         check_val("rst_hold", obs(), 32'd0);
      end
      rst = 1'b0;
      en  = 1'b0;
      tick();
      check_val("post_rst_idle", obs(), expv(3'd0, 7'd0, 1'b0, 1'b0, 1'b0));
   endtask

`ifndef CORE_SEQ_STEP_EN
   task automatic do_phase(input string tag, input logic [2:0] st, input logic [6:0] go,
                           input int d, input int which, input bit give,
                           input logic [2:0] cls_bits, input bit taken);
      for (int i = 0; i <= d; i++) begin
         check_val(tag, obs(), expv(st, (i == 0) ? go : 7'd0, 1'b0, 1'b0, retired > 0));
         drive_noise();
         case (which)
            0: imem_rdy = give && (i == d);
            1: reg_rdy  = give && (i == d);
            2: alu_done = give && (i == d);
            3: mem_ack  = give && (i == d);
            default: ;
         endcase
         if (which == 1 && i == d) {load_instr, store_instr, branch_instr} = cls_bits;
         if (which == 2 && i == d) branch_taken = taken;
         tick();
      end
   endtask

   // cls: 0 alu, 1 load, 2 store, 3 branch. Entered in the first FETCH cycle.
   task automatic run_instr(input int cls, input int df, input int dr, input int de,
                            input int dm, input bit taken, input bit en_next, input bit halt_req);
      logic [2:0] cb;
      logic       wbgo, sel;
      cb   = (cls == 1) ? 3'b100 : (cls == 2) ? 3'b010 : (cls == 3) ? 3'b001 : 3'b000;
      en   = en_next;
      halt = 1'b0;
      do_phase("fetch", 3'd1, G_FETCH, df, 0, 1'b1, cb, taken);
      do_phase("decode", 3'd2, G_DEC, 0, -1, 1'b1, cb, taken);
      do_phase("read", 3'd3, G_READ, dr, 1, 1'b1, cb, taken);
      halt = halt_req;
      do_phase("exec", 3'd4, G_EXEC, de, 2, 1'b1, cb, taken);
      if (cls == 1 || cls == 2) do_phase("mem", 3'd5, G_MEM, dm, 3, 1'b1, cb, taken);
      wbgo = (cls == 0) || (cls == 1);
      sel  = (cls == 3) && taken;
      check_val("wb", obs(), expv(3'd6, {5'd0, wbgo, 1'b1}, sel, 1'b0, retired > 0));
      check_val("wb_count", instr_count, 32'(retired));
      drive_noise();
      tick();
      retired++;
   endtask

   // Leaves the bench in the first FETCH cycle of the next instruction.
   task automatic after_instr(input bit h, input bit e);
      if (h) begin
         check_val("halted", obs(), expv(3'd7, 7'd0, 1'b0, 1'b0, 1'b1));
         tick();
         check_val("halted_hold", obs(), expv(3'd7, 7'd0, 1'b0, 1'b0, 1'b1));
         halt = 1'b0;
         en   = 1'b1;
         tick();
         check_val("halt_exit", obs(), expv(3'd0, 7'd0, 1'b0, 1'b0, 1'b1));
         tick();
      end else if (!e) begin
         check_val("idle", obs(), expv(3'd0, 7'd0, 1'b0, 1'b0, retired > 0));
         en = 1'b1;
         tick();
      end
   endtask

   function automatic int pick_delay();
      int r;
      r = int'($urandom % 8);
      return (r == 7) ? TO - 1 : (r < 4) ? 0 : r - 3;
   endfunction
`endif

   initial begin
      #2000000;
      $display("FAIL tb_timeout: simulation exceeded time limit");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst = 1'b1; en = 1'b0; halt = 1'b0;
      imem_rdy = 1'b0; reg_rdy = 1'b0; alu_done = 1'b0; mem_ack = 1'b0;
      load_instr = 1'b0; store_instr = 1'b0; branch_instr = 1'b0; branch_taken = 1'b0;
      tick();
      tick();
      check_val("reset", obs(), 32'd0);
      check_val("reset_cnt", instr_count, 32'd0);
      rst = 1'b0;
      tick();
      check_val("idle_after_reset", obs(), expv(3'd0, 7'd0, 1'b0, 1'b0, 1'b0));

`ifndef CORE_SEQ_STEP_EN
      en = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) run_instr(0, 0, 0, 0, 0, 1'b0, i < 9, 1'b0);
      check_val("run10_idle", obs(), expv(3'd0, 7'd0, 1'b0, 1'b0, 1'b1));
      check_val("run10_count", instr_count, 32'd10);
      en = 1'b1;
      tick();

      run_instr(1, 0, 0, 0, 3, 1'b0, 1'b1, 1'b0);
      run_instr(3, 1, 0, 2, 0, 1'b1, 1'b1, 1'b0);
      run_instr(2, 0, 2, 1, 1, 1'b1, 1'b1, 1'b1);
      after_instr(1'b1, 1'b1);

      for (int n = 0; n < 40; n++) begin
         int cls, df, dr, de, dm;
         bit tk, e, h;
         cls = int'($urandom % 4);
         df  = pick_delay();
         dr  = pick_delay();
         de  = pick_delay();
         dm  = pick_delay();
         tk  = 1'($urandom);
         e   = ($urandom % 4) != 0;
         h   = ($urandom % 6) == 0;
         run_instr(cls, df, dr, de, dm, tk, e, h);
         after_instr(h, e);
      end

      en = 1'b1;
      halt = 1'b0;
      do_phase("wd_fetch", 3'd1, G_FETCH, 0, 0, 1'b1, 3'b000, 1'b0);
      do_phase("wd_decode", 3'd2, G_DEC, 0, -1, 1'b1, 3'b000, 1'b0);
      do_phase("wd_read", 3'd3, G_READ, 0, 1, 1'b1, 3'b000, 1'b0);
      do_phase("wd_exec", 3'd4, G_EXEC, TO - 1, 2, 1'b0, 3'b000, 1'b0);
      for (int i = 0; i < 20; i++) begin
         check_val("err_frozen", obs(), expv(3'd0, 7'd0, 1'b0, 1'b1, 1'b1));
         drive_noise();
         en = 1'b1;
         tick();
      end
      check_val("err_count", instr_count, 32'(retired));

      rst = 1'b1;
      tick();
      rst = 1'b0;
      retired = 0;
      en = 1'b1;
      tick();
      run_instr(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
      check_val("rst_fetch", obs(), expv(3'd1, G_FETCH, 1'b0, 1'b0, 1'b1));
      imem_rdy = 1'b1;
      tick();
      reg_rdy = 1'b0;
      tick();
      reset_in_read();
`else
      imem_rdy = 1'b1; reg_rdy = 1'b1; alu_done = 1'b1; mem_ack = 1'b1;
      for (int p = 0; p < 3; p++) begin
         en = 1'b1;
         repeat (1 + $urandom_range(0, 2)) tick();
         check_val("step_wait", obs(), expv(3'd0, 7'd0, 1'b0, 1'b0, retired > 0));
         en = 1'b0;
         repeat (8) tick();
         retired++;
         check_val("step_idle", obs(), expv(3'd0, 7'd0, 1'b0, 1'b0, 1'b1));
         check_val("step_cnt", instr_count, 32'(retired));
      end
      repeat (10) tick();
      check_val("step_no_extra", instr_count, 32'(retired));
      reg_rdy = 1'b0;
      en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      tick();
      tick();
      reset_in_read();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the RISC-V core datapath. It walks each instruction through fetch, decode, operand read, execute, optional memory and writeback, and issues one-cycle `go` strobes to the instruction memory, PC unit, decoder, register block and ALU. It waits on each unit's ready/done handshake, detects stalled handshakes with a watchdog, and counts retired instructions. It replaces the free-running `enPulse` stepping currently distributed to every unit.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum wait cycles in any handshake state before an error is raised; legal range ≥ 2.
- `CNT_WIDTH`, default 32: width of the retired-instruction counter.
- `clk`  in  1: core clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: run/step control (see Configuration).
- `halt`  in  1: stop request; honoured only at an instruction boundary.
- `imem_rdy`  in  1: instruction word valid.
- `reg_rdy`  in  1: register operands valid.
- `alu_done`  in  1: ALU result valid.
- `mem_ack`  in  1: load/store complete.
- `load_instr`, `store_instr`, `branch_instr`  in  1 each: decoded class, sampled at the end of READ.
- `branch_taken`  in  1: sampled in the cycle `alu_done` is accepted.
- `fetch_go`, `decode_go`, `read_go`, `exec_go`, `mem_go`, `wb_go`, `pc_go`  out  1 each: one-cycle strobes.
- `sel_pc_src`  out  1: 1 selects the branch target at `pc_go`.
- `busy`  out  1: high in any state except IDLE, HALTED or ERR.
- `err`  out  1: watchdog error, sticky.
- `boot_ok`  out  1: sticky; set when the first instruction retires.
- `instr_count`  out  CNT_WIDTH: retired instruction count.
- `state`  out  3: encoded current state, for debug.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, READ=3, EXEC=4, MEM=5, WB=6, HALTED=7. ERR is a separate sticky flag. While `err` is set, the FSM is frozen in IDLE and all strobes are 0.
- Transitions:
  - IDLE → FETCH on a start condition, provided `halt` is 0.
  - FETCH → DECODE on `imem_rdy`.
  - DECODE → READ unconditionally after 1 cycle.
  - READ → EXEC on `reg_rdy`; the class inputs are latched on this edge.
  - EXEC → MEM if load or store, else EXEC → WB, on `alu_done`.
  - MEM → WB on `mem_ack`.
  - WB → FETCH if a start condition holds and `halt`=0; WB → HALTED if `halt`=1; otherwise WB → IDLE.
  - HALTED → IDLE when `halt` deasserts.
- Strobe rules:
  - Each state's strobe is high only in the first cycle of that state. A handshake input that is high in that same first cycle is accepted.
  - `wb_go` is asserted in WB only when neither store nor branch is latched.
  - `pc_go` is asserted in every WB cycle.
  - `sel_pc_src` equals the latched `branch_instr & branch_taken` and is valid while in WB; it is 0 elsewhere.
- Watchdog: the counter clears on every state entry and increments each cycle spent in FETCH, READ, EXEC or MEM without the awaited handshake. When it reaches TIMEOUT_CYCLES-1 with no handshake, the next edge sets `err` and forces IDLE. A handshake in that same cycle wins over the timeout.
- `instr_count` increments by 1 on each WB cycle and wraps modulo 2^CNT_WIDTH. `boot_ok` is set on the first WB.
- Handshake inputs that arrive while not in their waiting state are ignored.

## Timing
- Reset values: state=IDLE, all strobes 0, `sel_pc_src`=0, `busy`=0, `err`=0, `boot_ok`=0, `instr_count`=0. Asserting `rst` mid-instruction aborts immediately; no strobe is issued after reset.
- Minimum latency with all handshakes in their first cycle: 5 cycles per non-memory instruction (FETCH, DECODE, READ, EXEC, WB), 6 per load/store. Back-to-back run places `fetch_go` on the cycle after WB.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Simultaneous `halt` and start condition in WB: halt wins.

## Configuration
- Macro `CORE_SEQ_STEP_EN`:
  - Defined: single-step mode. An internal edge detector produces a start condition on each falling edge of `en` (registered `en` = 1 and current `en` = 0), so each pulse retires exactly one instruction. From WB with no new pulse pending, the FSM goes to IDLE.
  - Undefined: `en` is a level run enable, and the start condition is `en`=1. Deasserting `en` lets the current instruction finish, then the FSM goes to IDLE.

## Structure
- Shared package `riscv_pkg`: `seq_state_t` enum (3-bit encodings above) and `SEQ_TIMEOUT_DEFAULT`.
- Sub-module `seq_watchdog`: loadable clear/enable counter with a terminal-count output, parameterised by TIMEOUT_CYCLES.

## Test plan
- ALU op, run mode, all handshakes immediate, `en`=1 for 10 instructions → `fetch_go` every 5 cycles, `instr_count`=10, `boot_ok` set after the first WB.
- Load with `mem_ack` delayed 3 cycles → `mem_go` for 1 cycle, WB entered on the 4th MEM cycle, `wb_go`=1.
- Taken branch (`branch_instr`=1, `branch_taken`=1) → in WB, `sel_pc_src`=1, `pc_go`=1, `wb_go`=0.
- `alu_done` withheld, TIMEOUT_CYCLES=16 → `err`=1 after 16 EXEC cycles, state=IDLE, no further strobes until `rst`.
- `halt` asserted mid-EXEC → instruction completes through WB, then state=HALTED; after `halt` drops → IDLE.
- With `CORE_SEQ_STEP_EN`: three `en` high→low pulses → exactly 3 retirements. Also assert `rst` during READ → all outputs return to their reset values asynchronously.
